// File: rtl/i2c_slave_bus_port.sv
// Bus-side I2C slave engine: oversampled SCL/SDA, 7-bit address match, auto-incrementing RAM pointer.
// Define I2C_SLAVE_PTR_LOAD_EN to make the first write byte load the pointer instead of writing RAM.
module i2c_slave_bus_port #(
  parameter int PTR_WIDTH   = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  input  logic [6:0]           slaveAddr,
  output logic [PTR_WIDTH-1:0] masterRAM_WADD,
  output logic [7:0]           masterRAM_DIN,
  output logic                 masterRAM_W,
  output logic [PTR_WIDTH-1:0] slaveRAM_RADD,
  input  logic [7:0]           slaveRAM_DOUT,
  output logic                 busy,
  output logic [PTR_WIDTH-1:0] ptr
);

  // IDLE wait | ADDR rx addr | ADDR_ACK | WRITE rx data | WRITE_ACK | READ tx data | READ_ACK master ack
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda, w_start, w_stop, w_scl_r, w_scl_f, w_addr_match;

  state_t               r_state, w_state_nxt;
  logic [7:0]           r_shift, w_shift_nxt;
  logic [3:0]           r_bitcnt, w_bitcnt_nxt;
  logic                 r_sda_oe, w_sda_oe_nxt;
  logic                 r_busy, w_busy_nxt;
  logic [PTR_WIDTH-1:0] r_ptr, w_ptr_nxt;
  logic                 r_wr, w_wr_nxt;
  logic [PTR_WIDTH-1:0] r_wadd, w_wadd_nxt;
  logic [7:0]           r_din, w_din_nxt;
`ifdef I2C_SLAVE_PTR_LOAD_EN
  logic                 r_first, w_first_nxt;
`endif

  // Synchronisers idle high so reset release on a quiet bus creates no events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl        = r_scl_sync[SYNC_STAGES-1];
  assign w_sda        = r_sda_sync[SYNC_STAGES-1];
  assign w_start      = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop       = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_scl_r      = w_scl & ~r_scl_d;
  assign w_scl_f      = ~w_scl & r_scl_d;
  assign w_addr_match = (r_shift[7:1] == slaveAddr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_ptr    <= '0;
      r_wr     <= 1'b0;
      r_wadd   <= '0;
      r_din    <= '0;
`ifdef I2C_SLAVE_PTR_LOAD_EN
      r_first  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_sda_oe <= w_sda_oe_nxt;
      r_busy   <= w_busy_nxt;
      r_ptr    <= w_ptr_nxt;
      r_wr     <= w_wr_nxt;
      r_wadd   <= w_wadd_nxt;
      r_din    <= w_din_nxt;
`ifdef I2C_SLAVE_PTR_LOAD_EN
      r_first  <= w_first_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
    end else begin
      case (r_state)
        S_IDLE:      w_state_nxt = S_IDLE;
        S_ADDR:      if (w_scl_f && r_bitcnt == 4'd8) w_state_nxt = w_addr_match ? S_ADDR_ACK : S_IDLE;
        S_ADDR_ACK:  if (w_scl_f) w_state_nxt = r_shift[0] ? S_READ : S_WRITE;
        S_WRITE:     if (w_scl_f && r_bitcnt == 4'd8) w_state_nxt = S_WRITE_ACK;
        S_WRITE_ACK: if (w_scl_f) w_state_nxt = S_WRITE;
        S_READ:      if (w_scl_f && r_bitcnt == 4'd7) w_state_nxt = S_READ_ACK;
        S_READ_ACK:  if (w_scl_r) w_state_nxt = w_sda ? S_IDLE : S_READ;
        default:     w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_sda_oe_nxt = r_sda_oe;
    w_busy_nxt   = r_busy;
    w_ptr_nxt    = r_ptr;
    w_wr_nxt     = 1'b0;
    w_wadd_nxt   = r_wadd;
    w_din_nxt    = r_din;
`ifdef I2C_SLAVE_PTR_LOAD_EN
    w_first_nxt  = r_first;
`endif
    if (w_stop) begin
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_bitcnt_nxt = '0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_r && r_bitcnt < 4'd8) begin
            w_shift_nxt  = {r_shift[6:0], w_sda};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_f && r_bitcnt == 4'd8 && w_addr_match) begin
            w_sda_oe_nxt = 1'b1;
            w_busy_nxt   = 1'b1;
`ifdef I2C_SLAVE_PTR_LOAD_EN
            w_first_nxt  = 1'b1;
`else
            w_ptr_nxt    = '0;
`endif
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_f) begin
            w_bitcnt_nxt = '0;
            if (r_shift[0]) begin
              w_shift_nxt  = slaveRAM_DOUT;
              w_sda_oe_nxt = ~slaveRAM_DOUT[7];
            end else begin
              w_sda_oe_nxt = 1'b0;
            end
          end
        end
        S_WRITE: begin
          if (w_scl_r && r_bitcnt < 4'd8) begin
            w_shift_nxt  = {r_shift[6:0], w_sda};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_f && r_bitcnt == 4'd8) begin
            w_sda_oe_nxt = 1'b1;
`ifdef I2C_SLAVE_PTR_LOAD_EN
            w_first_nxt  = 1'b0;
            if (r_first) begin
              w_ptr_nxt = r_shift[PTR_WIDTH-1:0];
            end else begin
              w_wr_nxt   = 1'b1;
              w_wadd_nxt = r_ptr;
              w_din_nxt  = r_shift;
              w_ptr_nxt  = r_ptr + PTR_WIDTH'(1);
            end
`else
            w_wr_nxt   = 1'b1;
            w_wadd_nxt = r_ptr;
            w_din_nxt  = r_shift;
            w_ptr_nxt  = r_ptr + PTR_WIDTH'(1);
`endif
          end
        end
        S_WRITE_ACK: begin
          if (w_scl_f) begin
            w_sda_oe_nxt = 1'b0;
            w_bitcnt_nxt = '0;
          end
        end
        S_READ: begin
          // bitcnt==8 marks a byte fetched after master ACK, still to be loaded
          if (w_scl_f) begin
            if (r_bitcnt == 4'd8) begin
              w_shift_nxt  = slaveRAM_DOUT;
              w_sda_oe_nxt = ~slaveRAM_DOUT[7];
              w_bitcnt_nxt = '0;
            end else if (r_bitcnt == 4'd7) begin
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
              w_bitcnt_nxt = r_bitcnt + 4'd1;
            end
          end
        end
        S_READ_ACK: begin
          if (w_scl_r) begin
            if (w_sda) begin
              w_busy_nxt = 1'b0;
            end else begin
              w_ptr_nxt    = r_ptr + PTR_WIDTH'(1);
              w_bitcnt_nxt = 4'd8;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe         = r_sda_oe;
  assign busy           = r_busy;
  assign ptr            = r_ptr;
  assign slaveRAM_RADD  = r_ptr;
  assign masterRAM_W    = r_wr;
  assign masterRAM_WADD = r_wadd;
  assign masterRAM_DIN  = r_din;

endmodule

// File: tb/tb_i2c_slave_bus_port.sv
// Bench for i2c_slave_bus_port: bus-level master, transaction-level RAM/pointer model, per-cycle write checker.
module tb_i2c_slave_bus_port;
  localparam int Q = 8;
`ifdef I2C_SLAVE_PTR_LOAD_EN
  localparam bit PLE = 1'b1;
`else
  localparam bit PLE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic [6:0] slave_addr = 7'h42;
  logic       sda_oe, m_w, busy;
  logic [4:0] m_wadd, s_radd, ptr;
  logic [7:0] m_din, s_dout;
  wire        sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_bus_port dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .slaveAddr(slave_addr), .masterRAM_WADD(m_wadd), .masterRAM_DIN(m_din),
    .masterRAM_W(m_w), .slaveRAM_RADD(s_radd), .slaveRAM_DOUT(s_dout),
    .busy(busy), .ptr(ptr)
  );

  logic [7:0] sram [32];
  logic [7:0] mram [32];
  always @(posedge clk) s_dout <= sram[s_radd];

  logic [4:0] ew_addr [128];
  logic [7:0] ew_data [128];
  int         ew_n = 0;
  int         ew_i = 0;
  logic [4:0] mptr = 5'd0;
  logic [7:0] txq [$];
  logic [7:0] rxb [4];

  string chk_name;
  int    chk_act, chk_exp;
  int    chk_req = 0;
  int    chk_seen = 0;
  int    tests = 0;
  int    fails = 0;
  logic  prev_w, prev_oe;

  // Single compare process: directed checks posted by the stimulus, plus every write strobe
  initial begin
    prev_w = 1'b0;
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_req != chk_seen) begin
        chk_seen = chk_req;
        tests++;
        if (chk_act != chk_exp) begin
          fails++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", chk_name, chk_act, chk_exp);
        end
      end
      if (!reset) begin
        if (m_w) begin
          tests++;
          mram[m_wadd] = m_din;
          if (ew_i >= ew_n || prev_w) begin
            fails++;
            $display("FAIL wr_pulse: got write [%0d]=0x%0h (prev_w=%0b), expected no write", m_wadd, m_din, prev_w);
          end else begin
            if (m_wadd != ew_addr[ew_i] || m_din != ew_data[ew_i]) begin
              fails++;
              $display("FAIL wr_data: got [%0d]=0x%0h, expected [%0d]=0x%0h", m_wadd, m_din, ew_addr[ew_i], ew_data[ew_i]);
            end
            ew_i++;
          end
        end
        if (sda_oe != prev_oe) begin
          tests++;
          if (scl) begin
            fails++;
            $display("FAIL oe_timing: got sda_oe change with scl=%0b, expected scl=0", scl);
          end
        end
      end
      prev_w = m_w;
      prev_oe = sda_oe;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    chk_name = name;
    chk_act = act;
    chk_exp = exp;
    chk_req++;
    @(negedge clk);
    #1;
  endtask

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; q_wait();
    scl = 1'b1;   q_wait();
    sda_m = 1'b0; q_wait();
    scl = 1'b0;   q_wait();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; q_wait();
    scl = 1'b1;   q_wait();
    sda_m = 1'b1; q_wait();
  endtask

  task automatic bus_bit(input logic b, output logic r);
    sda_m = b; q_wait();
    scl = 1'b1; q_wait();
    r = sda_line; q_wait();
    scl = 1'b0; q_wait();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    bus_bit(1'b1, r);
    acked = ~r;
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
    bus_bit(~m_ack, r);
  endtask

  // Model: pointer restarts at 0 on a match (or keeps/loads with PLE); each byte lands at ptr, ptr wraps mod 32
  task automatic write_txn(input logic [7:0] abyte, input bit do_stop);
    logic       match, acked;
    logic [4:0] p;
    logic [7:0] b;
    match = (abyte[7:1] == slave_addr) && !abyte[0];
    p = PLE ? mptr : 5'd0;
    bus_start();
    send_byte(abyte, acked);
    check("addr_ack", acked, match);
    if (match) check("busy_after_addr", busy, 1);
    for (int i = 0; i < txq.size(); i++) begin
      b = txq[i];
      if (match) begin
        if (PLE && i == 0) begin
          p = b[4:0];
        end else begin
          ew_addr[ew_n] = p;
          ew_data[ew_n] = b;
          ew_n++;
          p = p + 5'd1;
        end
      end
      send_byte(b, acked);
      check("data_ack", acked, match);
    end
    if (match) mptr = p;
    if (do_stop) bus_stop();
  endtask

  task automatic read_txn(input logic [7:0] abyte, input int n, input bit do_stop);
    logic       acked;
    logic [4:0] p;
    logic [7:0] d;
    p = PLE ? mptr : 5'd0;
    bus_start();
    send_byte(abyte, acked);
    check("rd_addr_ack", acked, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i != n - 1, d);
      rxb[i] = d;
      check("rd_data", d, sram[p]);
      if (i != n - 1) p = p + 5'd1;
    end
    mptr = p;
    check("busy_after_nack", busy, 0);
    check("oe_after_nack", sda_oe, 0);
    if (do_stop) bus_stop();
  endtask

  initial begin
    logic       acked, o_oe, o_w, o_busy;
    logic [4:0] o_ptr;
    logic [7:0] d;
    for (int i = 0; i < 32; i++) sram[i] = 8'((i + 1) * 16) | 8'(i / 16);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_w", m_w, 0);
    check("rst_ptr", ptr, 0);
    check("rst_busy", busy, 0);
    check("rst_wadd", m_wadd, 0);
    check("rst_din", m_din, 0);
    check("rst_radd", s_radd, 0);

    txq.delete(); txq.push_back(8'h41); txq.push_back(8'h42);
    write_txn(8'h84, 1'b1);
    check("busy_after_stop", busy, 0);
    check("ptr_after_wr", ptr, mptr);
`ifdef I2C_SLAVE_PTR_LOAD_EN
    check("lit_wr_mram1", mram[1], 8'h42);
    check("lit_wr_ptr", ptr, 2);
`else
    check("lit_wr_mram0", mram[0], 8'h41);
    check("lit_wr_mram1", mram[1], 8'h42);
    check("lit_wr_ptr", ptr, 2);
`endif

    txq.delete(); txq.push_back(8'h99); txq.push_back(8'h5A);
    write_txn(8'h86, 1'b1);
    check("busy_mismatch", busy, 0);
    check("ptr_mismatch", ptr, mptr);

    read_txn(8'h85, 3, 1'b1);
    check("ptr_after_rd", ptr, mptr);
`ifndef I2C_SLAVE_PTR_LOAD_EN
    check("lit_rd0", rxb[0], 8'h10);
    check("lit_rd1", rxb[1], 8'h20);
    check("lit_rd2", rxb[2], 8'h30);
    check("lit_rd_ptr", ptr, 2);
`endif

    txq.delete();
    for (int i = 0; i <= 32; i++) txq.push_back(8'(i));
    write_txn(8'h84, 1'b1);
    check("ptr_after_wrap", ptr, mptr);
`ifdef I2C_SLAVE_PTR_LOAD_EN
    check("lit_wrap_mram0", mram[0], 8'h01);
    check("lit_wrap_mram31", mram[31], 8'h20);
    check("lit_wrap_ptr", ptr, 0);
`else
    check("lit_wrap_mram0", mram[0], 8'h20);
    check("lit_wrap_mram31", mram[31], 8'h1F);
    check("lit_wrap_ptr", ptr, 1);
`endif

    txq.delete(); txq.push_back(8'h1E); txq.push_back(8'h55); txq.push_back(8'h66);
    write_txn(8'h84, 1'b0);
    check("ptr_after_load", ptr, mptr);
`ifdef I2C_SLAVE_PTR_LOAD_EN
    check("lit_load_mram30", mram[30], 8'h55);
    check("lit_load_mram31", mram[31], 8'h66);
    check("lit_load_ptr", ptr, 0);
`else
    check("lit_load_mram2", mram[2], 8'h66);
    check("lit_load_ptr", ptr, 3);
`endif
    read_txn(8'h85, 1, 1'b1);
    check("lit_rs_rd0", rxb[0], 8'h10);

    // Reset while the slave drives SDA inside the second read byte (sram[1]=0x20, bit7=0)
    bus_start();
    send_byte(8'h85, acked);
    check("rst_addr_ack", acked, 1);
    recv_byte(1'b1, d);
    check("rst_rd0", d, sram[PLE ? mptr : 5'd0]);
    check("rst_oe_before", sda_oe, 1);
    check("rst_busy_before", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    o_oe = sda_oe; o_w = m_w; o_ptr = ptr; o_busy = busy;
    check("async_rst_oe", o_oe, 0);
    check("async_rst_w", o_w, 0);
    check("async_rst_ptr", o_ptr, 0);
    check("async_rst_busy", o_busy, 0);
    scl = 1'b1;
    sda_m = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mptr = 5'd0;
    repeat (5) @(negedge clk);
    check("post_rst_ptr", ptr, 0);
    check("writes_all_seen", ew_i, ew_n);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_slave_bus_port.md
Name: i2c_slave_bus_port

Overview:
- Bus-side I2C slave protocol engine; receives SCL/SDA from the master and serves its read and write transactions.
- Writes each received data byte into master RAM through the masterRAM_W/WADD/DIN write port.
- Fetches each byte to transmit from slave RAM through slaveRAM_RADD/slaveRAM_DOUT; read data is registered and appears 1 clk after the address.
- Holds a 5-bit auto-incrementing byte pointer shared by reads and writes; oversamples the bus with clk (clk >= 16x SCL).

Parameters:
PTR_WIDTH, 5, pointer and RAM address width (32 entries)
SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronisers

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
scl_in  in  1  raw SCL pin level
sda_in  in  1  raw SDA pin level
sda_oe  out  1  1 = pull SDA low (open drain); 0 = release
slaveAddr  in  7  own 7-bit address, sampled at address compare
masterRAM_WADD  out  5  master RAM write address
masterRAM_DIN  out  8  master RAM write data
masterRAM_W  out  1  1-clk write strobe
slaveRAM_RADD  out  5  slave RAM read address
slaveRAM_DOUT  in  8  slave RAM data, valid 1 clk after RADD
busy  out  1  high from addressed ACK until STOP, NACK or START
ptr  out  5  current byte pointer, for menu display

Behaviour:
- Reset (async): every output 0; FSM in IDLE; shift register and bit counter cleared.
- Inputs pass through the SYNC_STAGES synchronisers, then one extra register for edge detection.
  - Event latency is SYNC_STAGES+1 clk after the pin change.
- Events, each a 1-clk pulse:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - SCL_R / SCL_F: SCL rising / falling edge.
- STOP, from any state: go to IDLE; sda_oe=0; busy=0.
- START, from any state (repeated start included): go to ADDR; bit count=0; sda_oe=0.
- Sampling and driving: SDA is sampled on SCL_R; sda_oe changes only on SCL_F.
- FSM states and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first.
    - On the SCL_F after bit 8: if [7:1]==slaveAddr, set sda_oe=1 (ACK) and go to ADDR_ACK.
    - On mismatch go to IDLE; bus stays released.
    - On match without PTR_LOAD_EN, ptr is cleared to 0.
  - ADDR_ACK: on the next SCL_F release SDA.
    - R/W=0: go to WRITE.
    - R/W=1: slaveRAM_RADD=ptr is already presented; load the shift register from slaveRAM_DOUT; drive sda_oe=~bit7 on that same SCL_F; go to READ.
  - WRITE: shift 8 bits.
    - On the SCL_F after bit 8: masterRAM_WADD=ptr, masterRAM_DIN=byte, masterRAM_W=1 for exactly 1 clk.
    - Same clk: ptr=ptr+1; sda_oe=1; go to WRITE_ACK.
  - WRITE_ACK: release SDA on the next SCL_F; go to WRITE.
  - READ: on each SCL_F drive sda_oe=~next bit.
    - After 8 bits, the next SCL_F releases SDA; go to READ_ACK.
  - READ_ACK: sample the master's bit on SCL_R.
    - 0 (ACK): ptr=ptr+1 and slaveRAM_RADD=ptr+1 in the same clk; the byte is loaded before the following SCL_F; go to READ.
    - 1 (NACK): go to IDLE with busy=0.
- Pointer wraps 31 -> 0 on both read and write; no error indication.
- slaveAddr changes take effect at the next address compare only.
- masterRAM_W never asserts in IDLE, ADDR or READ states.
- Reset mid-transfer: SDA is released immediately and no partial byte is written.

Optional Feature:
I2C_SLAVE_PTR_LOAD_EN
- Defined:
  - ptr is not cleared on address match.
  - In a write transaction, the first data byte after the address loads ptr=byte[4:0] and is ACKed, but masterRAM_W does not assert.
  - Following bytes write normally.
  - A repeated-start read then begins at the loaded ptr.
- Undefined: ptr is cleared to 0 at every address match; every write data byte goes to RAM.

Test Plan:
- Reset asserted mid-READ with sda_oe=1 -> sda_oe, masterRAM_W, ptr, busy all 0 within 1 clk, asynchronously.
- slaveAddr=0x42; write addr 0x84, data 0x41, 0x42, then STOP -> master RAM [0]=0x41, [1]=0x42; two 1-clk W pulses; ACK on all 3 bytes; ptr=2.
- Address 0x86 (mismatch) then data -> no ACK (sda_oe stays 0), no W pulse, busy=0.
- Slave RAM [0..2]=0x10, 0x20, 0x30; read addr 0x85, master ACK, ACK, NACK -> SDA carries 0x10, 0x20, 0x30; FSM returns to IDLE.
- 33 written bytes 0x00..0x20 -> entry 0 ends at 0x20 (wrap); ptr=1.
- PTR_LOAD_EN defined: write 0x84, 0x1E, 0x55, 0x66 -> no W for 0x1E; [30]=0x55, [31]=0x66; ptr=0. Then repeated-start read 0x85 -> first byte sent is slave RAM [0].
